// File: rtl/gcm_pkg.sv
// Shared types and constants for the GCM job sequencer.
package gcm_pkg;

  localparam int unsigned BLK_W = 128;
  localparam int unsigned IV_W  = 96;

  localparam logic [63:0] GCM_BLK_BITS = 64'd128;

  typedef enum logic [2:0] {
    IDLE,
    START,
    PT,
    WAIT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/gcm_job_sequencer_if.sv
// Job, result and core-facing signal bundle of the GCM job sequencer.
interface gcm_job_sequencer_if import gcm_pkg::*; #(
  parameter int unsigned CNT_W = 16
) ();

  logic               i_job_valid;
  logic               o_job_ready;
  logic [0:IV_W-1]    i_iv;
  logic [0:BLK_W-1]   i_cipher_key;
  logic [0:BLK_W-1]   i_plain_text;
  logic [0:BLK_W-1]   i_aad;

  logic [0:IV_W-1]    o_core_iv;
  logic [0:BLK_W-1]   o_core_cipher_key;
  logic [0:BLK_W-1]   o_core_plain_text;
  logic [0:BLK_W-1]   o_core_aad;
  logic [63:0]        o_core_plain_text_size;
  logic [63:0]        o_core_aad_size;
  logic               o_core_new_instance;
  logic               o_core_pt_instance;
  logic [0:BLK_W-1]   i_core_cipher_text;
  logic [0:BLK_W-1]   i_core_tag;
  logic               i_core_tag_ready;

  logic               o_res_valid;
  logic               i_res_ready;
  logic [0:BLK_W-1]   o_cipher_text;
  logic [0:BLK_W-1]   o_tag;
  logic               o_timeout;
  logic               o_busy;
  logic [CNT_W-1:0]   o_job_count;

  // Sequencer side
  modport slave (
    input  i_job_valid, i_iv, i_cipher_key, i_plain_text, i_aad,
    input  i_core_cipher_text, i_core_tag, i_core_tag_ready, i_res_ready,
    output o_job_ready, o_core_iv, o_core_cipher_key, o_core_plain_text, o_core_aad,
    output o_core_plain_text_size, o_core_aad_size, o_core_new_instance, o_core_pt_instance,
    output o_res_valid, o_cipher_text, o_tag, o_timeout, o_busy, o_job_count
  );

  // Host plus core side
  modport master (
    output i_job_valid, i_iv, i_cipher_key, i_plain_text, i_aad,
    output i_core_cipher_text, i_core_tag, i_core_tag_ready, i_res_ready,
    input  o_job_ready, o_core_iv, o_core_cipher_key, o_core_plain_text, o_core_aad,
    input  o_core_plain_text_size, o_core_aad_size, o_core_new_instance, o_core_pt_instance,
    input  o_res_valid, o_cipher_text, o_tag, o_timeout, o_busy, o_job_count
  );

endinterface

// File: rtl/gcm_seq_timer.sv
// Loadable up-counter with clear, enable and terminal-count flag.
module gcm_seq_timer #(
  parameter int unsigned W  = 12,
  parameter int unsigned TC = 4095
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (clr)  count <= '0;
    else if (load) count <= load_val;
    else if (en)   count <= count + W'(1);
  end

  assign tc_c = (count == W'(TC));

endmodule

// File: rtl/gcm_job_sequencer.sv
// Drives one gcm_aes core through single-block jobs with a bounded wait for the tag.
module gcm_job_sequencer import gcm_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 i_reset,
  gcm_job_sequencer_if.slave   bus
);

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  seq_state_t state;
  logic       tag_prev;
  logic       tag_edge_c;
  logic       tmr_clr_c;
  logic       tmr_en_c;
  logic       tmr_tc_c;

  assign bus.o_core_plain_text_size = GCM_BLK_BITS;
  assign bus.o_core_aad_size        = GCM_BLK_BITS;

  // Completion needs a fresh rise; a level left high from a prior job is ignored.
  assign tag_edge_c = bus.i_core_tag_ready && !tag_prev;
  assign tmr_clr_c  = (state == PT);
  assign tmr_en_c   = (state == WAIT) && !tag_edge_c;

  gcm_seq_timer #(
    .W  (TMR_W),
    .TC (TIMEOUT_CYCLES - 1)
  ) u_timer (
    .clk      (clk),
    .rst      (i_reset),
    .clr      (tmr_clr_c),
    .load     (1'b0),
    .load_val ('0),
    .en       (tmr_en_c),
    .tc_c     (tmr_tc_c)
  );

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state                   <= IDLE;
      tag_prev                <= 1'b0;
      bus.o_job_ready         <= 1'b1;
      bus.o_core_iv           <= '0;
      bus.o_core_cipher_key   <= '0;
      bus.o_core_plain_text   <= '0;
      bus.o_core_aad          <= '0;
      bus.o_core_new_instance <= 1'b0;
      bus.o_core_pt_instance  <= 1'b0;
      bus.o_res_valid         <= 1'b0;
      bus.o_cipher_text       <= '0;
      bus.o_tag               <= '0;
      bus.o_timeout           <= 1'b0;
      bus.o_busy              <= 1'b0;
      bus.o_job_count         <= '0;
    end else begin
      bus.o_core_new_instance <= 1'b0;
      bus.o_core_pt_instance  <= 1'b0;
      tag_prev                <= bus.i_core_tag_ready;

      case (state)
        IDLE: begin
          if (bus.i_job_valid && bus.o_job_ready) begin
            bus.o_core_iv           <= bus.i_iv;
            bus.o_core_cipher_key   <= bus.i_cipher_key;
            bus.o_core_plain_text   <= bus.i_plain_text;
            bus.o_core_aad          <= bus.i_aad;
            bus.o_core_new_instance <= 1'b1;
            bus.o_job_ready         <= 1'b0;
            bus.o_busy              <= 1'b1;
            state                   <= START;
          end
        end
        START: begin
          bus.o_core_pt_instance <= 1'b1;
          tag_prev               <= 1'b1;
          state                  <= PT;
        end
        PT: state <= WAIT;
        WAIT: begin
          // An edge arriving on the terminal cycle still wins over the timeout.
          if (tag_edge_c) begin
            bus.o_cipher_text <= bus.i_core_cipher_text;
            bus.o_tag         <= bus.i_core_tag;
            bus.o_timeout     <= 1'b0;
            bus.o_job_count   <= bus.o_job_count + CNT_W'(1);
            bus.o_res_valid   <= 1'b1;
            state             <= DONE;
          end else if (tmr_tc_c) begin
            bus.o_cipher_text <= '0;
            bus.o_tag         <= '0;
            bus.o_timeout     <= 1'b1;
            bus.o_res_valid   <= 1'b1;
            state             <= DONE;
          end
        end
        DONE: begin
          if (bus.i_res_ready) begin
            bus.o_res_valid <= 1'b0;
            bus.o_job_ready <= 1'b1;
            bus.o_busy      <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gcm_job_sequencer.md
Name: gcm_job_sequencer

Overview:
- Sequences one gcm_aes core through single-block GCM jobs, with a valid/ready job interface in and a valid/ready result interface out.
- Registers job operands, pulses new_instance, then pt_instance one cycle later, waits for a fresh tag_ready edge, captures cipher text and tag, and holds them until consumed.
- Bounds each job with a timeout.
- Sits between host/switch logic and gcm_aes, replacing ad-hoc reset/pt_delay sequencing.

Parameters:
- TIMEOUT_CYCLES, 4096: max WAIT-state cycles before the job aborts with o_timeout.
- CNT_W, 16: width of the completed-job counter.

Ports:
- clk  in  1  core clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_job_valid  in  1  job request.
- o_job_ready  out  1  high only in IDLE.
- i_iv  in  [0:95]  job IV.
- i_cipher_key  in  [0:127]  job key.
- i_plain_text  in  [0:127]  job plain text block.
- i_aad  in  [0:127]  job AAD block.
- o_core_iv  out  [0:95]  registered IV to core.
- o_core_cipher_key  out  [0:127]  registered key to core.
- o_core_plain_text  out  [0:127]  registered plain text to core.
- o_core_aad  out  [0:127]  registered AAD to core.
- o_core_plain_text_size  out  64  constant 64'd128.
- o_core_aad_size  out  64  constant 64'd128.
- o_core_new_instance  out  1  one-cycle start pulse.
- o_core_pt_instance  out  1  one-cycle plain-text pulse.
- i_core_cipher_text  in  [0:127]  core result.
- i_core_tag  in  [0:127]  core tag.
- i_core_tag_ready  in  1  core tag-valid level.
- o_res_valid  out  1  result available.
- i_res_ready  in  1  result consumed.
- o_cipher_text  out  [0:127]  captured cipher text.
- o_tag  out  [0:127]  captured tag.
- o_timeout  out  1  qualifies the result: job aborted.
- o_busy  out  1  state != IDLE.
- o_job_count  out  CNT_W  successful jobs completed.

Behaviour:
- Reset (async, i_reset=1):
  - State = IDLE.
  - Every output register = 0, except o_job_ready = 1.
  - Size outputs are constant.
- States: IDLE -> START -> PT -> WAIT -> DONE -> IDLE.
- IDLE:
  - On i_job_valid && o_job_ready, latch all four operands into the o_core_* registers.
  - Next state START.
  - Operands stay stable until the next accept.
- START:
  - o_core_new_instance=1 for exactly this cycle.
  - tag_prev cleared to 1 so a stale high tag_ready cannot complete the job.
- PT:
  - o_core_pt_instance=1 for exactly this cycle (one cycle after new_instance).
  - Timeout counter cleared.
- WAIT:
  - Completes on a rising edge of i_core_tag_ready: i_core_tag_ready=1 and tag_prev=0, with tag_prev the registered previous value.
  - On completion, capture i_core_cipher_text and i_core_tag into o_cipher_text/o_tag, set o_timeout=0, increment o_job_count (wraps mod 2^CNT_W), and go to DONE.
  - Otherwise increment the counter. If the counter reaches TIMEOUT_CYCLES-1 with no edge, set o_timeout=1, zero o_cipher_text and o_tag, leave o_job_count unchanged, and go to DONE.
  - An edge and the timeout in the same cycle count as success.
- DONE:
  - o_res_valid=1.
  - Outputs held while i_res_ready=0.
  - On i_res_ready, o_res_valid drops next cycle and state returns to IDLE.
  - i_job_valid is ignored while not in IDLE; no queueing.
- Latency: accept edge to first possible o_res_valid = 3 + core latency cycles. new_instance is asserted on cycle 1 after accept, pt_instance on cycle 2.
- Reset mid-job: immediate abort to IDLE. Pulses and o_res_valid deassert asynchronously, and no result is produced.
- Pulses are never asserted outside START/PT. Both pulses are never high together.

Decomposition:
- gcm_pkg:
  - typedef seq_state_t enum {IDLE, START, PT, WAIT, DONE}.
  - Block/IV width constants BLK_W=128, IV_W=96.
  - Size constant GCM_BLK_BITS=64'd128.
- Sub-module gcm_seq_timer: loadable up-counter with clear, enable and terminal-count flag. Instantiated once for the WAIT timeout.

Test Plan:
- Job handshake pulses: reset, then job with iv=96'h0, key=128'h0, pt=128'h0, aad=128'h0. Required: new_instance high 1 cycle at accept+1, pt_instance high 1 cycle at accept+2, o_job_ready low from accept+1. Stub core raises tag_ready 10 cycles later with tag=128'h58E2FCCEFA7E3061367F1D57A4E7455A. Required: o_res_valid with that o_tag, o_timeout=0, o_job_count=1.
- Stale tag_ready: stub holds tag_ready=1 from before the accept. Required: no completion until tag_ready drops and re-rises; captured data comes from the re-rise cycle.
- Timeout: TIMEOUT_CYCLES=16, tag_ready held 0. Required: o_res_valid with o_timeout=1, o_tag=0, o_job_count unchanged, 16 cycles after the PT cycle.
- Backpressure: i_res_ready=0 for 20 cycles in DONE while core outputs change. Required: o_tag/o_cipher_text are stable; a second i_job_valid is not accepted until 1 cycle after i_res_ready.
- Async reset in WAIT: assert i_reset mid-cycle. Required: o_busy=0, o_res_valid=0, o_job_ready=1 immediately; the following job runs normally.
- Counter wrap: CNT_W=2, five successful jobs. Required: o_job_count sequence 1,2,3,0,1.
